// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID->EX pipeline register for a 5-stage RV32I core. It captures the decoded
//   control bundle, operands, immediate and register indices from ID every
//   cycle. It also detects a load-use hazard against the instruction already in
//   EX and inserts a bubble when one is found. Branch/jump flush and downstream
//   hold are handled here too.
//
//   Edge priority: flush -> bubble, hold -> retain, load-use -> bubble,
//   otherwise capture ID.
//
// Optional feature (macro ID_EX_BUBBLE_CNT_EN):
//   When defined, the bubble_cnt port exists. The counter saturates and
//   counts only load-use bubbles.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   id_valid            ID slot holds a real instruction
//   id_pc, id_rs1_data, id_rs2_data, id_imm     XLEN-wide data
//   id_rs1, id_rs2, id_rd, id_funct3            register indices / funct3
//   id_jum .. id_writeback                      decoder control bits
//   flush               redirect from EX, kills the ID instruction
//   hold                stall from MEM/WB, freezes this register
//   load_use_stall      combinational, freezes PC and IF/ID
//   ex_valid, ex_*      registered copy of the ID bundle
//   bubble_cnt          saturating load-use bubble count (macro only)
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_jum,
  input  logic            id_branch,
  input  logic            id_wen_rf,
  input  logic            id_alu_src,
  input  logic            id_en_dmem,
  input  logic            id_load_store,
  input  logic [3:0]      id_alu_ctrl,
  input  logic [2:0]      id_funct3_dmem,
  input  logic [1:0]      id_writeback,
  input  logic            flush,
  input  logic            hold,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_jum,
  output logic            ex_branch,
  output logic            ex_wen_rf,
  output logic            ex_alu_src,
  output logic            ex_en_dmem,
  output logic            ex_load_store,
  output logic [3:0]      ex_alu_ctrl,
  output logic [2:0]      ex_funct3_dmem,
  output logic [1:0]      ex_writeback
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  // A load in EX (dmem enabled, not a store) writing a non-zero rd forces a
  // stall when either ID source matches. Both sources are always compared,
  // even for formats that lack rs2. This is conservative but cheap. A flush
  // cancels the stall, because the ID instruction is being killed anyway.
  logic ex_is_load;
  logic src_match;

  assign ex_is_load     = ex_valid & ex_en_dmem & ~ex_load_store & ex_wen_rf
                          & (ex_rd != 5'd0);
  assign src_match      = (id_rs1 == ex_rd) | (id_rs2 == ex_rd);
  assign load_use_stall = ex_is_load & id_valid & src_match & ~flush;

  // A bubble is produced by a flush (highest priority) or by a load-use stall
  // that is not overridden by hold.
  logic insert_bubble;
  assign insert_bubble = flush | (~hold & load_use_stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
      ex_jum         <= 1'b0;
      ex_branch      <= 1'b0;
      ex_wen_rf      <= 1'b0;
      ex_alu_src     <= 1'b0;
      ex_en_dmem     <= 1'b0;
      ex_load_store  <= 1'b0;
      ex_alu_ctrl    <= '0;
      ex_funct3_dmem <= '0;
      ex_writeback   <= '0;
    end else if (insert_bubble) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
      ex_jum         <= 1'b0;
      ex_branch      <= 1'b0;
      ex_wen_rf      <= 1'b0;
      ex_alu_src     <= 1'b0;
      ex_en_dmem     <= 1'b0;
      ex_load_store  <= 1'b0;
      ex_alu_ctrl    <= '0;
      ex_funct3_dmem <= '0;
      ex_writeback   <= '0;
    end else if (!hold) begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_rs1_data    <= id_rs1_data;
      ex_rs2_data    <= id_rs2_data;
      ex_imm         <= id_imm;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_rd          <= id_rd;
      ex_funct3      <= id_funct3;
      // An invalid slot carries its data along, but every control bit is
      // masked. This ensures it can never write the RF or DMEM, or redirect.
      ex_jum         <= id_jum & id_valid;
      ex_branch      <= id_branch & id_valid;
      ex_wen_rf      <= id_wen_rf & id_valid;
      ex_alu_src     <= id_alu_src & id_valid;
      ex_en_dmem     <= id_en_dmem & id_valid;
      ex_load_store  <= id_load_store & id_valid;
      ex_alu_ctrl    <= id_valid ? id_alu_ctrl : 4'd0;
      ex_funct3_dmem <= id_valid ? id_funct3_dmem : 3'd0;
      ex_writeback   <= id_valid ? id_writeback : 2'd0;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  // Counts only bubbles caused by the load-use rule. Flush bubbles and
  // held stall cycles do not count.
  logic count_bubble;
  assign count_bubble = ~flush & ~hold & load_use_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (count_bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

  localparam int XLEN = 32;
  // A narrow counter keeps the saturation test short.
  localparam int CNT_W = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        jum;
    logic        branch;
    logic        wen_rf;
    logic        alu_src;
    logic        en_dmem;
    logic        load_store;
    logic [3:0]  alu_ctrl;
    logic [2:0]  funct3_dmem;
    logic [1:0]  writeback;
  } bundle_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst_n;
  logic    flush;
  logic    hold;
  bundle_t idb;
  bundle_t act;

  logic            load_use_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic            ex_jum, ex_branch, ex_wen_rf, ex_alu_src, ex_en_dmem, ex_load_store;
  logic [3:0]      ex_alu_ctrl;
  logic [2:0]      ex_funct3_dmem;
  logic [1:0]      ex_writeback;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] exp_cnt;
`endif

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (idb.valid),
    .id_pc          (idb.pc),
    .id_rs1_data    (idb.rs1_data),
    .id_rs2_data    (idb.rs2_data),
    .id_imm         (idb.imm),
    .id_rs1         (idb.rs1),
    .id_rs2         (idb.rs2),
    .id_rd          (idb.rd),
    .id_funct3      (idb.funct3),
    .id_jum         (idb.jum),
    .id_branch      (idb.branch),
    .id_wen_rf      (idb.wen_rf),
    .id_alu_src     (idb.alu_src),
    .id_en_dmem     (idb.en_dmem),
    .id_load_store  (idb.load_store),
    .id_alu_ctrl    (idb.alu_ctrl),
    .id_funct3_dmem (idb.funct3_dmem),
    .id_writeback   (idb.writeback),
    .flush          (flush),
    .hold           (hold),
    .load_use_stall (load_use_stall),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_rs1_data    (ex_rs1_data),
    .ex_rs2_data    (ex_rs2_data),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_rd          (ex_rd),
    .ex_funct3      (ex_funct3),
    .ex_jum         (ex_jum),
    .ex_branch      (ex_branch),
    .ex_wen_rf      (ex_wen_rf),
    .ex_alu_src     (ex_alu_src),
    .ex_en_dmem     (ex_en_dmem),
    .ex_load_store  (ex_load_store),
    .ex_alu_ctrl    (ex_alu_ctrl),
    .ex_funct3_dmem (ex_funct3_dmem),
    .ex_writeback   (ex_writeback)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt     (bubble_cnt)
`endif
  );

  assign act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_funct3, ex_jum, ex_branch, ex_wen_rf, ex_alu_src, ex_en_dmem,
                ex_load_store, ex_alu_ctrl, ex_funct3_dmem, ex_writeback};

  int n_cmp = 0;
  int n_bad = 0;
  bundle_t sb[$];

  function automatic void chk_b(string name, bundle_t a, bundle_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end else begin
      $display("ok   %s: %h", name, a);
    end
  endfunction

  function automatic void chk_v(string name, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end else begin
      $display("ok   %s: %0h", name, a);
    end
  endfunction

  // Monitor: one EX-register comparison after each edge that has a pending expectation.
  initial begin
    bundle_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_b("ex_bundle", act, e);
      end
    end
  end

  // Entered just after a negedge, with the ID inputs already applied.
  task automatic cycle(input bundle_t e, input logic lus_exp, input string tag);
    #1;
    chk_v({tag, " load_use_stall"}, {31'd0, load_use_stall}, {31'd0, lus_exp});
    sb.push_back(e);
`ifdef ID_EX_BUBBLE_CNT_EN
    if (lus_exp && !hold && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
`endif
    @(posedge clk);
    #1;
`ifdef ID_EX_BUBBLE_CNT_EN
    chk_v({tag, " bubble_cnt"}, {{(32-CNT_W){1'b0}}, bubble_cnt}, {{(32-CNT_W){1'b0}}, exp_cnt});
`endif
    @(negedge clk);
  endtask

  // Directed vectors:  valid pc rs1_data rs2_data imm rs1 rs2 rd f3 jum br wen asrc dmem ls aluc f3d wb
  localparam bundle_t ZERO = '0;
  localparam bundle_t ADD  = '{1'b1, 32'h100, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 2'd0};
  localparam bundle_t LW5  = '{1'b1, 32'h104, 32'h1000, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, 3'd2,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 3'd2, 2'd1};
  localparam bundle_t USE5 = '{1'b1, 32'h108, 32'h33, 32'h44, 32'd0, 5'd5, 5'd2, 5'd6, 3'd0,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 2'd0};
  localparam bundle_t LW0  = '{1'b1, 32'h10c, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd0, 5'd0, 3'd2,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 3'd2, 2'd1};
  localparam bundle_t USE0 = '{1'b1, 32'h110, 32'h0, 32'h9, 32'd0, 5'd0, 5'd4, 5'd7, 3'd0,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 2'd0};
  localparam bundle_t SW5  = '{1'b1, 32'h114, 32'h2000, 32'h55, 32'h4, 5'd1, 5'd5, 5'd5, 3'd2,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 3'd2, 2'd0};
  localparam bundle_t USEB = '{1'b1, 32'h118, 32'h11, 32'h22, 32'd0, 5'd9, 5'd5, 5'd8, 3'd0,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 3'd0, 2'd0};
  localparam bundle_t BEQ  = '{1'b1, 32'h120, 32'd1, 32'd1, 32'hFFFF_FFF0, 5'd3, 5'd4, 5'd0, 3'd0,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 3'd0, 2'd0};
  localparam bundle_t INV  = '{1'b0, 32'h200, 32'hAA, 32'hBB, 32'hCC, 5'd5, 5'd6, 5'd7, 3'd5,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 3'd7, 2'd3};
  localparam bundle_t INVX = '{1'b0, 32'h200, 32'hAA, 32'hBB, 32'hCC, 5'd5, 5'd6, 5'd7, 3'd5,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 2'd0};

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    idb   = ZERO;
`ifdef ID_EX_BUBBLE_CNT_EN
    exp_cnt = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_b("reset_state", act, ZERO);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain capture: add x3,x1,x2.
    idb = ADD;
    cycle(ADD, 1'b0, "add");

    // Asynchronous reset between edges, while EX holds a valid RF-writing instruction.
    #2 rst_n = 1'b0;
    #1;
    chk_b("async_reset", act, ZERO);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk_v("async_reset bubble_cnt", {{(32-CNT_W){1'b0}}, bubble_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load-use: the bubble is inserted, then the dependent instruction is captured.
    idb = LW5;  cycle(LW5, 1'b0, "lw_x5");
    idb = USE5; cycle(ZERO, 1'b1, "use_x5_stall");
    cycle(USE5, 1'b0, "use_x5_capture");

    // A load to x0 never stalls.
    idb = LW0;  cycle(LW0, 1'b0, "lw_x0");
    idb = USE0; cycle(USE0, 1'b0, "use_x0");

    // A store in EX never stalls, even if rd matches.
    idb = SW5;  cycle(SW5, 1'b0, "sw");
    idb = USE5; cycle(USE5, 1'b0, "after_sw");

    // Flush and hold together, with load-use conditions true: flush wins and suppresses the stall.
    idb = LW5;  cycle(LW5, 1'b0, "lw_x5_b");
    idb = USE5; flush = 1'b1; hold = 1'b1;
    cycle(ZERO, 1'b0, "flush_hold");
    flush = 1'b0; hold = 1'b0;

    // Hold together with load-use: the register holds and the stall is still driven.
    idb = LW5;  cycle(LW5, 1'b0, "lw_x5_c");
    idb = USEB; hold = 1'b1;
    cycle(LW5, 1'b1, "hold_lus");
    hold = 1'b0;
    cycle(ZERO, 1'b1, "lus_after_hold");
    cycle(USEB, 1'b0, "useb_capture");

    // Hold for 3 cycles while ID changes, then capture the current ID.
    idb = BEQ; cycle(BEQ, 1'b0, "beq");
    hold = 1'b1;
    idb = ADD;  cycle(BEQ, 1'b0, "hold1");
    idb = LW5;  cycle(BEQ, 1'b0, "hold2");
    idb = USE0; cycle(BEQ, 1'b0, "hold3");
    hold = 1'b0;
    cycle(USE0, 1'b0, "release");

    // Flush alone.
    idb = ADD; flush = 1'b1;
    cycle(ZERO, 1'b0, "flush");
    flush = 1'b0;

    // Invalid ID slot: the data passes through, the controls are masked, and no stall occurs.
    idb = LW5; cycle(LW5, 1'b0, "lw_x5_d");
    idb = INV; cycle(INVX, 1'b0, "invalid");
    idb = ADD; cycle(ADD, 1'b0, "add_after_inv");

`ifdef ID_EX_BUBBLE_CNT_EN
    // Counter saturation: force 2^CNT_W+3 load-use bubbles.
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      idb = LW5;  cycle(LW5, 1'b0, "sat_lw");
      idb = USE5; cycle(ZERO, 1'b1, "sat_stall");
    end
    chk_v("bubble_cnt_saturated", {{(32-CNT_W){1'b0}}, bubble_cnt}, (32'd1 << CNT_W) - 32'd1);
`endif

    @(posedge clk);
    #2;
    chk_v("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
